// File: rtl/keypad_scanner_pkg.sv
// Shared types for the keypad scanner slice.
//   state_e : scan FSM states (IDLE / DRIVE / PROC)
//   evt_t   : event record {code[5:0], press}
package keypad_scanner_pkg;

  localparam int unsigned KEY_W = 6;
  localparam int unsigned EVT_W = KEY_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_PROC  = 2'd2
  } state_e;

  typedef struct packed {
    logic [KEY_W-1:0] code;
    logic             press;
  } evt_t;

endpackage

// File: rtl/keypad_scanner_evt_fifo.sv
// evt_fifo: generic synchronous show-ahead FIFO.
//   clk, rst   : clock, synchronous active-high reset
//   push, din  : write request and data (ignored when full unless popping)
//   pop        : consume head (ignored when empty)
//   dout       : head entry, '0 when empty
//   full/empty : occupancy flags
module evt_fifo #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH   = 1 << AW;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_push, do_pop;

  always_comb begin
    empty   = (wptr_q == rptr_q);
    full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_pop  = pop && !empty;
    // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
    do_push = push && (!full || do_pop);

    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) begin
      mem_d[wptr_q[AW-1:0]] = din;
      wptr_d                = wptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end

    dout = empty ? '0 : mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 8x8 matrix reader with per-key debounce and event FIFO.
//   CLK, RST          : clock, synchronous active-high reset
//   EN                : scan enable; low halts scan and blanks ROW
//   ROW[7:0]          : one-hot row strobe
//   COLUMN[7:0]       : asynchronous column returns, 1 = pressed
//   KEYS[63:0]        : debounced key map, bit = row*8+col
//   FRAME             : one-cycle pulse after row 7 is processed
//   EVT_VALID/READY   : event handshake
//   EVT_CODE/PRESS    : head event (key index, 1 = press)
//   OVERFLOW          : sticky, event dropped on a full FIFO
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned SETTLE   = 16,
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned FIFO_AW  = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  output logic [7:0]  ROW,
  input  logic [7:0]  COLUMN,
  output logic [63:0] KEYS,
  output logic        FRAME,
  output logic        EVT_VALID,
  input  logic        EVT_READY,
  output logic [5:0]  EVT_CODE,
  output logic        EVT_PRESS,
  output logic        OVERFLOW
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [2:0] DB_LAST     = 3'(DEBOUNCE - 1);

  logic [7:0]  col_s1_q, col_s2_q;
  state_e      state_q, state_d;
  logic [2:0]  row_q, row_d;
  logic [2:0]  col_q, col_d;
  logic [7:0]  settle_q, settle_d;
  logic [7:0]  samp_q, samp_d;
  logic [63:0] keys_q, keys_d;
  logic [2:0]  cnt_q [64];
  logic [2:0]  cnt_d [64];
  logic        frame_q, frame_d;
  logic        ovf_q, ovf_d;

  logic [KEY_W-1:0] key_idx;
  logic             push;
  evt_t             push_evt;
  evt_t             head_evt;
  logic             fifo_full, fifo_empty;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      col_s1_q <= '0;
      col_s2_q <= '0;
      state_q  <= ST_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      settle_q <= '0;
      samp_q   <= '0;
      keys_q   <= '0;
      frame_q  <= 1'b0;
      ovf_q    <= 1'b0;
      for (int unsigned i = 0; i < 64; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      col_s1_q <= COLUMN;
      col_s2_q <= col_s1_q;
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      settle_q <= settle_d;
      samp_q   <= samp_d;
      keys_q   <= keys_d;
      frame_q  <= frame_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    settle_d = settle_q;
    samp_d   = samp_q;
    if (!EN) begin
      state_d  = ST_IDLE;
      row_d    = '0;
      col_d    = '0;
      settle_d = '0;
      samp_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d  = ST_DRIVE;
          row_d    = '0;
          settle_d = '0;
        end
        ST_DRIVE: begin
          if (settle_q == SETTLE_LAST) begin
            samp_d   = col_s2_q;
            state_d  = ST_PROC;
            col_d    = '0;
            settle_d = '0;
          end else begin
            settle_d = settle_q + 8'd1;
          end
        end
        ST_PROC: begin
          col_d = col_q + 3'd1;
          if (col_q == 3'd7) begin
            state_d = ST_DRIVE;
            row_d   = row_q + 3'd1;   // 7 wraps to 0
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    ROW     = (state_q == ST_IDLE) ? 8'h00 : (8'b1 << row_q);
    frame_d = EN && (state_q == ST_PROC) && (col_q == 3'd7) && (row_q == 3'd7);
  end

  // Debounce: one key per PROC cycle, so at most one push per cycle
  always_comb begin
    key_idx  = {row_q, col_q};
    keys_d   = keys_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    push_evt = '0;
    if (EN && (state_q == ST_PROC)) begin
      if (samp_q[col_q] == keys_q[key_idx]) begin
        cnt_d[key_idx] = '0;
      end else if (cnt_q[key_idx] == DB_LAST) begin
        keys_d[key_idx] = ~keys_q[key_idx];
        cnt_d[key_idx]  = '0;
        push            = 1'b1;
        push_evt.code   = key_idx;
        push_evt.press  = ~keys_q[key_idx];
      end else begin
        cnt_d[key_idx] = cnt_q[key_idx] + 3'd1;
      end
    end
    ovf_d = ovf_q | (push & fifo_full & ~(EVT_READY & ~fifo_empty));
  end

  evt_fifo #(
    .WIDTH (EVT_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .din   (push_evt),
    .pop   (EVT_READY),
    .dout  (head_evt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign KEYS      = keys_q;
  assign FRAME     = frame_q;
  assign OVERFLOW  = ovf_q;
  assign EVT_VALID = ~fifo_empty;
  assign EVT_CODE  = head_evt.code;
  assign EVT_PRESS = head_evt.press;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN = 1'b0;
  logic [7:0]  ROW;
  logic [7:0]  COLUMN;
  logic [63:0] KEYS;
  logic        FRAME;
  logic        EVT_VALID;
  logic        EVT_READY = 1'b0;
  logic [5:0]  EVT_CODE;
  logic        EVT_PRESS;
  logic        OVERFLOW;

  logic [63:0] held = '0;
  logic [6:0]  evq [$];
  int          t = 0;
  int          n_chk = 0;
  int          n_err = 0;

  keypad_scanner #(
    .SETTLE   (16),
    .DEBOUNCE (3),
    .FIFO_AW  (2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .ROW       (ROW),
    .COLUMN    (COLUMN),
    .KEYS      (KEYS),
    .FRAME     (FRAME),
    .EVT_VALID (EVT_VALID),
    .EVT_READY (EVT_READY),
    .EVT_CODE  (EVT_CODE),
    .EVT_PRESS (EVT_PRESS),
    .OVERFLOW  (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  // Matrix model: a held key shorts its row strobe onto its column.
  always_comb begin
    COLUMN = '0;
    for (int r = 0; r < 8; r++) begin
      if (ROW[r]) COLUMN = COLUMN | held[r*8 +: 8];
    end
  end

  // Event consumer: record every accepted handshake.
  always @(negedge CLK) begin
    if (!RST && EVT_VALID && EVT_READY) evq.push_back({EVT_CODE, EVT_PRESS});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
    t++;
  endtask

  task automatic run_to(input int target);
    while (t < target) cyc();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_row"},   ROW,       64'h0);
    check({tag, "_keys"},  KEYS,      64'h0);
    check({tag, "_frame"}, FRAME,     64'h0);
    check({tag, "_valid"}, EVT_VALID, 64'h0);
    check({tag, "_code"},  EVT_CODE,  64'h0);
    check({tag, "_press"}, EVT_PRESS, 64'h0);
    check({tag, "_ovf"},   OVERFLOW,  64'h0);
  endtask

  // Reset with EN=1; t=0 is the first DRIVE cycle of row 0.
  task automatic restart(input logic [63:0] keys_held, input logic ready);
    held      = keys_held;
    EVT_READY = ready;
    EN        = 1'b1;
    RST       = 1'b1;
    cyc();
    RST = 1'b0;
    cyc();
    t = 0;
    evq.delete();
  endtask

  initial begin
    // Reset values
    RST = 1'b1;
    cyc();
    cyc();
    check_reset_vals("rst");

    // Press (2,5): row sequence, debounce to frame 3, single press event
    restart(64'h1 << 21, 1'b0);
    check("frame_first", FRAME, 64'h0);
    for (int i = 0; i < 192; i++) begin
      run_to(i);
      check("row_seq", ROW, 64'h1 << (i / 24));
    end
    run_to(192);
    check("frame_pulse", FRAME, 64'h1);
    cyc();
    check("frame_low", FRAME, 64'h0);
    run_to(2*192 + 69);
    check("k21_pre", KEYS, 64'h0);
    check("k21_pre_valid", EVT_VALID, 64'h0);
    run_to(2*192 + 70);
    check("k21_set", KEYS, 64'h1 << 21);
    check("k21_valid", EVT_VALID, 64'h1);
    check("k21_code", EVT_CODE, 64'd21);
    check("k21_press", EVT_PRESS, 64'h1);
    run_to(2*192 + 74);
    check("k21_hold_code", EVT_CODE, 64'd21);
    EVT_READY = 1'b1;
    cyc();
    EVT_READY = 1'b0;
    check("k21_nevt", evq.size(), 64'd1);
    if (evq.size() > 0) check("k21_evt", evq[0], {6'd21, 1'b1});
    check("k21_drained", EVT_VALID, 64'h0);

    // Reset mid-DRIVE with (2,5) still held
    run_to(3*192 + 5);
    check("pre_rst_keys", KEYS, 64'h1 << 21);
    RST = 1'b1;
    cyc();
    check_reset_vals("midrst");
    RST = 1'b0;
    EVT_READY = 1'b1;
    cyc();
    t = 0;
    evq.delete();
    run_to(2*192 + 69);
    check("rehold_pre", KEYS, 64'h0);
    run_to(2*192 + 70);
    check("rehold_set", KEYS, 64'h1 << 21);
    run_to(3*192);
    check("rehold_nevt", evq.size(), 64'd1);
    if (evq.size() > 0) check("rehold_evt", evq[0], {6'd21, 1'b1});

    // 2-frame glitch on (7,0), then a real press and release
    restart(64'h1 << 56, 1'b1);
    run_to(2*192);
    held = '0;
    run_to(4*192);
    check("glitch_keys", KEYS, 64'h0);
    check("glitch_nevt", evq.size(), 64'd0);
    held = 64'h1 << 56;
    run_to(6*192 + 184);
    check("k56_pre", KEYS, 64'h0);
    run_to(6*192 + 185);
    check("k56_set", KEYS, 64'h1 << 56);
    run_to(7*192);
    check("k56_nevt", evq.size(), 64'd1);
    if (evq.size() > 0) check("k56_press", evq[0], {6'd56, 1'b1});
    held = '0;
    run_to(10*192);
    check("k56_rel_keys", KEYS, 64'h0);
    check("k56_rel_nevt", evq.size(), 64'd2);
    if (evq.size() > 1) check("k56_release", evq[1], {6'd56, 1'b0});

    // Six presses in row 0 with READY low: four queued, overflow
    restart(64'h3F, 1'b0);
    run_to(2*192 + 20);
    check("ovf_pre", OVERFLOW, 64'h0);
    check("ovf_pre_valid", EVT_VALID, 64'h1);
    cyc();
    check("ovf_set", OVERFLOW, 64'h1);
    run_to(3*192);
    check("ovf_keys", KEYS, 64'h3F);
    check("ovf_sticky", OVERFLOW, 64'h1);
    check("ovf_head_code", EVT_CODE, 64'd0);
    check("ovf_head_press", EVT_PRESS, 64'h1);
    EVT_READY = 1'b1;
    repeat (4) cyc();
    EVT_READY = 1'b0;
    check("ovf_nevt", evq.size(), 64'd4);
    for (int i = 0; i < 4 && i < evq.size(); i++) begin
      check("ovf_order", evq[i], {6'(i), 1'b1});
    end
    check("ovf_empty", EVT_VALID, 64'h0);
    check("ovf_still", OVERFLOW, 64'h1);

    // Full FIFO with a pop in the same cycle as a push
    restart(64'h1F, 1'b0);
    run_to(2*192 + 20);
    check("full_head", EVT_CODE, 64'd0);
    EVT_READY = 1'b1;
    cyc();
    EVT_READY = 1'b0;
    check("full_noovf", OVERFLOW, 64'h0);
    check("full_valid", EVT_VALID, 64'h1);
    check("full_newhead", EVT_CODE, 64'd1);
    EVT_READY = 1'b1;
    repeat (4) cyc();
    EVT_READY = 1'b0;
    check("full_nevt", evq.size(), 64'd5);
    for (int i = 0; i < 5 && i < evq.size(); i++) begin
      check("full_order", evq[i], {6'(i), 1'b1});
    end
    check("full_drained", EVT_VALID, 64'h0);
    check("full_keys", KEYS, 64'h1F);
    evq.delete();

    // EN low during PROC of row 4, then restart from row 0
    run_to(3*192 + 115);
    check("halt_row_pre", ROW, 64'h10);
    EN = 1'b0;
    cyc();
    check("halt_row", ROW, 64'h0);
    check("halt_keys", KEYS, 64'h1F);
    repeat (3) cyc();
    check("halt_row_idle", ROW, 64'h0);
    EN = 1'b1;
    cyc();
    t = 0;
    check("resume_row0", ROW, 64'h01);
    run_to(24);
    check("resume_row1", ROW, 64'h02);
    run_to(192);
    check("resume_frame", FRAME, 64'h1);
    check("resume_keys", KEYS, 64'h1F);
    check("resume_nevt", evq.size(), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
